// File: rtl/demux_pkg.sv
// ============================================================================
// demux_pkg : shared types and constants for the 1xN stream demultiplexer
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package demux_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PKT  = 2'd1,
      DROP = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/demux_sat_cnt.sv
// ============================================================================
// demux_sat_cnt : up-counter that sticks at all-ones
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_sat_cnt
   import demux_pkg::*;
#(
   parameter int W = CNT_W
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/demux_stream_1xn.sv
// ============================================================================
// demux_stream_1xn : packet-locked 1-to-N stream demux, one output register
//                    stage; optional statistics under DEMUX_STATS_EN
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_stream_1xn
   import demux_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int N_CH   = 4,
   localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [SEL_W-1:0]  s_sel,
   input  logic              s_last,
   output logic [N_CH-1:0]   m_valid,
   input  logic [N_CH-1:0]   m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              sel_err
`ifdef DEMUX_STATS_EN
   ,
   output logic [N_CH*CNT_W-1:0] beat_cnt,
   output logic [CNT_W-1:0]      drop_cnt
`endif
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SEL_W-1:0]    r_lock_ch;
   logic [SEL_W-1:0]    r_dst;
   logic [SEL_W-1:0]    w_dst;
   logic [DATA_W-1:0]   r_data;
   logic                r_full;
   logic                r_last;
   logic                r_sel_err;
   logic                r_rdy_en;
   logic                w_sel_bad;
   logic                w_out_ready;
   logic                w_acc;
   logic                w_drop;
   logic                w_push;

   assign w_sel_bad   = (32'(s_sel) >= 32'(N_CH));
   // Drain readiness follows the channel of the buffered beat, which for a
   // single-beat packet is not the locked channel.
   assign w_out_ready = m_ready[r_dst];
   assign s_ready     = r_rdy_en && ((r_state == DROP) || !r_full || w_out_ready);
   assign w_acc       = s_valid && s_ready;
   assign w_push      = w_acc && !w_drop;

   always_comb begin
      w_state_nxt = r_state;
      w_drop      = 1'b0;
      w_dst       = r_lock_ch;
      case (r_state)
         IDLE: begin
            w_dst  = s_sel;
            w_drop = w_sel_bad;
            if (w_acc && !s_last) begin
               w_state_nxt = w_sel_bad ? DROP : PKT;
            end
         end
         PKT: begin
            if (w_acc && s_last) w_state_nxt = IDLE;
         end
         DROP: begin
            w_drop = 1'b1;
            if (w_acc && s_last) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_ch <= '0;
         r_dst     <= '0;
         r_data    <= '0;
         r_full    <= 1'b0;
         r_last    <= 1'b0;
         r_sel_err <= 1'b0;
         r_rdy_en  <= 1'b0;
      end else begin
         r_rdy_en  <= 1'b1;
         r_sel_err <= w_acc && (r_state == IDLE) && w_sel_bad;
         if ((r_state == IDLE) && w_acc && !s_last && !w_sel_bad) begin
            r_lock_ch <= s_sel;
         end
         if (w_push) begin
            r_full <= 1'b1;
            r_dst  <= w_dst;
            r_data <= s_data;
            r_last <= s_last;
         end else if (r_full && w_out_ready) begin
            r_full <= 1'b0;
         end
      end
   end

   generate
      for (genvar c = 0; c < N_CH; c++) begin : g_mvalid
         assign m_valid[c] = r_full && (r_dst == SEL_W'(c));
      end
   endgenerate

   assign m_data  = r_data;
   assign m_last  = r_last;
   assign sel_err = r_sel_err;

`ifdef DEMUX_STATS_EN
   generate
      for (genvar c = 0; c < N_CH; c++) begin : g_beat_cnt
         demux_sat_cnt #(.W(CNT_W)) u_beat_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (m_valid[c] && m_ready[c]),
            .cnt   (beat_cnt[c*CNT_W +: CNT_W])
         );
      end
   endgenerate

   demux_sat_cnt #(.W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_acc && w_drop),
      .cnt   (drop_cnt)
   );
`else
   // Statistics disabled: no counters or count ports.
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_stream_1xn.sv
// ============================================================================
// tb_demux_stream_1xn : directed bench for demux_stream_1xn (N_CH=4 and N_CH=3)
// Revision            : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_stream_1xn;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       s4_valid, s4_ready, s4_last, m4_last, e4;
   logic [7:0] s4_data, m4_data;
   logic [1:0] s4_sel;
   logic [3:0] m4_valid, m4_ready;

   logic       s3_valid, s3_ready, s3_last, m3_last, e3;
   logic [7:0] s3_data, m3_data;
   logic [1:0] s3_sel;
   logic [2:0] m3_valid, m3_ready;

`ifdef DEMUX_STATS_EN
   logic [63:0] bc4;
   logic [15:0] dc4;
   logic [47:0] bc3;
   logic [15:0] dc3;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   demux_stream_1xn #(.DATA_W(8), .N_CH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s4_valid), .s_ready(s4_ready), .s_data(s4_data),
      .s_sel(s4_sel), .s_last(s4_last),
      .m_valid(m4_valid), .m_ready(m4_ready), .m_data(m4_data),
      .m_last(m4_last), .sel_err(e4)
`ifdef DEMUX_STATS_EN
      , .beat_cnt(bc4), .drop_cnt(dc4)
`endif
   );

   demux_stream_1xn #(.DATA_W(8), .N_CH(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s3_valid), .s_ready(s3_ready), .s_data(s3_data),
      .s_sel(s3_sel), .s_last(s3_last),
      .m_valid(m3_valid), .m_ready(m3_ready), .m_data(m3_data),
      .m_last(m3_last), .sel_err(e3)
`ifdef DEMUX_STATS_EN
      , .beat_cnt(bc3), .drop_cnt(dc3)
`endif
   );

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic [1:0] sel;
      logic       last;
      logic [3:0] mr;
      logic       rdy;   // s_ready expected before the edge
      logic [3:0] mv;    // registered outputs expected after the edge
      logic [7:0] md;
      logic       ml;
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int errs;

      vt[0] = '{1'b1, 8'hA5, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0100, 8'hA5, 1'b1};
      vt[1] = '{1'b1, 8'h11, 2'd1, 1'b0, 4'b1111, 1'b1, 4'b0010, 8'h11, 1'b0};
      vt[2] = '{1'b1, 8'h22, 2'd3, 1'b0, 4'b1111, 1'b1, 4'b0010, 8'h22, 1'b0};
      vt[3] = '{1'b1, 8'h33, 2'd3, 1'b1, 4'b1111, 1'b1, 4'b0010, 8'h33, 1'b1};
      vt[4] = '{1'b0, 8'h00, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 8'h00, 1'b0};
      vt[5] = '{1'b1, 8'h44, 2'd3, 1'b1, 4'b1111, 1'b1, 4'b1000, 8'h44, 1'b1};
      vt[6] = '{1'b1, 8'h50, 2'd0, 1'b0, 4'b1001, 1'b1, 4'b0001, 8'h50, 1'b0};
      vt[7] = '{1'b1, 8'h51, 2'd2, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'h51, 1'b1};
      vt[8] = '{1'b0, 8'h00, 2'd0, 1'b0, 4'b0000, 1'b0, 4'b0001, 8'h51, 1'b1};
      vt[9] = '{1'b0, 8'h00, 2'd0, 1'b0, 4'b0001, 1'b1, 4'b0000, 8'h00, 1'b0};

      rst_n    = 1'b0;
      s4_valid = 1'b0; s4_data = 8'h00; s4_sel = 2'd0; s4_last = 1'b0; m4_ready = 4'b0000;
      s3_valid = 1'b0; s3_data = 8'h00; s3_sel = 2'd0; s3_last = 1'b0; m3_ready = 3'b000;

      // reset state
      #2;
      chk("rst m_valid", 64'(m4_valid), 64'(4'b0000));
      chk("rst m_last",  64'(m4_last),  64'(1'b0));
      chk("rst m_data",  64'(m4_data),  64'(8'h00));
      chk("rst sel_err", 64'(e4),       64'(1'b0));
      chk("rst s_ready", 64'(s4_ready), 64'(1'b0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post-rst s_ready before edge", 64'(s4_ready), 64'(1'b0));
      tick();
      chk("post-rst s_ready after edge", 64'(s4_ready), 64'(1'b1));

      // table vectors
      for (int i = 0; i < 10; i++) begin
         s4_valid = vt[i].v;
         s4_data  = vt[i].d;
         s4_sel   = vt[i].sel;
         s4_last  = vt[i].last;
         m4_ready = vt[i].mr;
         #1;
         chk($sformatf("vec%0d s_ready", i), 64'(s4_ready), 64'(vt[i].rdy));
         tick();
         chk($sformatf("vec%0d m_valid", i), 64'(m4_valid), 64'(vt[i].mv));
         if (vt[i].mv != 4'b0000) begin
            chk($sformatf("vec%0d m_data", i), 64'(m4_data), 64'(vt[i].md));
            chk($sformatf("vec%0d m_last", i), 64'(m4_last), 64'(vt[i].ml));
         end
         chk($sformatf("vec%0d sel_err", i), 64'(e4), 64'(1'b0));
      end

      // back-pressure on channel 0, then resume with no bubble
      s4_valid = 1'b1; s4_data = 8'h60; s4_sel = 2'd0; s4_last = 1'b0; m4_ready = 4'b0000;
      #1;
      chk("bp first s_ready", 64'(s4_ready), 64'(1'b1));
      tick();
      chk("bp first m_valid", 64'(m4_valid), 64'(4'b0001));
      s4_data = 8'h61;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp stall%0d s_ready", k), 64'(s4_ready), 64'(1'b0));
         tick();
         chk($sformatf("bp stall%0d m_data", k), 64'(m4_data), 64'(8'h60));
         chk($sformatf("bp stall%0d m_valid", k), 64'(m4_valid), 64'(4'b0001));
      end
      m4_ready = 4'b0001;
      #1;
      chk("bp resume s_ready", 64'(s4_ready), 64'(1'b1));
      tick();
      chk("bp resume m_data", 64'(m4_data), 64'(8'h61));
      chk("bp resume m_valid", 64'(m4_valid), 64'(4'b0001));
      s4_data = 8'h62; s4_last = 1'b1;
      #1;
      chk("bp last s_ready", 64'(s4_ready), 64'(1'b1));
      tick();
      chk("bp last m_data", 64'(m4_data), 64'(8'h62));
      chk("bp last m_last", 64'(m4_last), 64'(1'b1));
      s4_valid = 1'b0; s4_last = 1'b0;
      tick();
      chk("bp drained m_valid", 64'(m4_valid), 64'(4'b0000));

      // invalid select on the 3-channel instance
      errs = 0;
      s3_valid = 1'b1; s3_sel = 2'd3; m3_ready = 3'b111;
      for (int b = 0; b < 4; b++) begin
         s3_data = 8'(8'h90 + b);
         s3_last = (b == 3);
         #1;
         chk($sformatf("drop beat%0d s_ready", b), 64'(s3_ready), 64'(1'b1));
         tick();
         errs += int'(e3);
         chk($sformatf("drop beat%0d sel_err", b), 64'(e3), 64'(b == 0));
         chk($sformatf("drop beat%0d m_valid", b), 64'(m3_valid), 64'(3'b000));
      end
      s3_valid = 1'b0; s3_last = 1'b0;
      tick();
      chk("drop sel_err pulses", 64'(errs), 64'(1));
      chk("drop m_valid after", 64'(m3_valid), 64'(3'b000));
`ifdef DEMUX_STATS_EN
      chk("drop_cnt", 64'(dc3), 64'(16'd4));
`endif
      s3_valid = 1'b1; s3_sel = 2'd3; s3_last = 1'b1; s3_data = 8'hEE;
      tick();
      chk("single invalid sel_err", 64'(e3), 64'(1'b1));
      chk("single invalid m_valid", 64'(m3_valid), 64'(3'b000));
      s3_sel = 2'd0; s3_data = 8'h5A;
      tick();
      chk("after invalid sel_err", 64'(e3), 64'(1'b0));
      chk("after invalid m_valid", 64'(m3_valid), 64'(3'b001));
      chk("after invalid m_data", 64'(m3_data), 64'(8'h5A));
      s3_valid = 1'b0; s3_last = 1'b0;
      tick();

      // reset in the middle of a packet
      s4_valid = 1'b1; s4_data = 8'h70; s4_sel = 2'd2; s4_last = 1'b0; m4_ready = 4'b1111;
      tick();
      chk("midrst beat1 m_valid", 64'(m4_valid), 64'(4'b0100));
      s4_data = 8'h71;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst m_valid", 64'(m4_valid), 64'(4'b0000));
      chk("midrst s_ready", 64'(s4_ready), 64'(1'b0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("midrst release s_ready", 64'(s4_ready), 64'(1'b0));
      tick();
      s4_data = 8'h80; s4_sel = 2'd0; s4_last = 1'b1;
      #1;
      chk("midrst restart s_ready", 64'(s4_ready), 64'(1'b1));
      tick();
      chk("midrst restart m_valid", 64'(m4_valid), 64'(4'b0001));
      chk("midrst restart m_data", 64'(m4_data), 64'(8'h80));
      chk("midrst restart m_last", 64'(m4_last), 64'(1'b1));
      s4_valid = 1'b0; s4_last = 1'b0;
      tick();

`ifdef DEMUX_STATS_EN
      // counter saturation on channel 3
      do_reset();
      s4_valid = 1'b1; s4_sel = 2'd3; s4_last = 1'b1; s4_data = 8'hC3; m4_ready = 4'b1111;
      repeat (65540) @(posedge clk);
      #1;
      s4_valid = 1'b0; s4_last = 1'b0;
      tick();
      tick();
      chk("sat beat_cnt[3]", 64'(bc4[63:48]), 64'(16'hFFFF));
      chk("sat beat_cnt[2:0]", 64'(bc4[47:0]), 64'(48'h0));
      chk("sat drop_cnt", 64'(dc4), 64'(16'h0));
      chk("sat other inst", 64'(bc3), 64'(48'h0));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
